// File: rtl/clk_ctrl_defs.sv
// Shared definitions for the clock rate controller.
// State encoding, config field positions, reset defaults.
package clk_ctrl_defs;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HIGH = 2'd1,
        ST_HELD = 2'd2
    } cpu_state_t;

    localparam int CFG_SEL_LSB = 0;
    localparam int CFG_SEL_W   = 3;
    localparam int CFG_RUN_BIT = 7;

    typedef struct packed {
        logic                 run;
        logic [CFG_SEL_W-1:0] sel;
    } cfg_t;

    localparam logic [CFG_SEL_W-1:0] RST_SEL = '0;
    localparam logic                 RST_RUN = 1'b1;
    localparam cfg_t                 RST_CFG = '{run: RST_RUN, sel: RST_SEL};

    // Last phase count of a half period of 2^sel base ticks.
    function automatic logic [7:0] half_term(logic [CFG_SEL_W-1:0] sel);
        return (8'd1 << sel) - 8'd1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-DIV counter advancing on en.
// wrap is high in the enabled cycle that returns the count to zero.
module tick_divider #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Count enabled cycles, wrapping at DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_rate_controller.sv
// Derives a programmable-rate CPU clock and a timer tick from clock_in.
// Rate/run changes take effect only at LOW terminals or in HELD.
module clock_rate_controller
    import clk_ctrl_defs::*;
#(
    parameter int PRE_DIV  = 5,
    parameter int TICK_DIV = 16,
    parameter int N_STALL  = 2
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_data,
    input  logic [N_STALL-1:0] stall_req,
    output logic               cpu_clk,
    output logic               cpu_rise,
    output logic               tim_tick,
    output logic [2:0]         rate_sel,
    output logic               cfg_pending
);

    logic       base_tick;
    logic       timer_wrap;
    cpu_state_t state;
    logic [7:0] phase_cnt;
    logic       run_act;
    cfg_t       pend;
    logic       terminal;
    logic       apply;
    logic       next_run;
    logic       go;
    logic       cfg_unused;

    assign cfg_unused = ^cfg_data[6:3];

    tick_divider #(.DIV(PRE_DIV)) u_pre (
        .clk  (clock_in),
        .rst  (reset),
        .en   (1'b1),
        .wrap (base_tick)
    );

    tick_divider #(.DIV(TICK_DIV)) u_tim (
        .clk  (clock_in),
        .rst  (reset),
        .en   (base_tick),
        .wrap (timer_wrap)
    );

    // Register the timer wrap so tim_tick is a clean flop output.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) tim_tick <= 1'b0;
        else       tim_tick <= timer_wrap;
    end

    assign terminal = base_tick && (phase_cnt == half_term(rate_sel));
    assign apply    = ((state == ST_LOW) && terminal)
                   || ((state == ST_HELD) && base_tick);
    assign next_run = cfg_pending ? pend.run : run_act;
    assign go       = next_run && !(|stall_req);

    // CPU clock FSM with config apply and write handling.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state       <= ST_LOW;
            phase_cnt   <= '0;
            cpu_clk     <= 1'b0;
            cpu_rise    <= 1'b0;
            rate_sel    <= RST_SEL;
            run_act     <= RST_RUN;
            pend        <= RST_CFG;
            cfg_pending <= 1'b0;
        end else begin
            cpu_rise <= 1'b0;
            if (base_tick) phase_cnt <= phase_cnt + 8'd1;
            if (apply && cfg_pending) begin
                rate_sel    <= pend.sel;
                run_act     <= pend.run;
                cfg_pending <= 1'b0;
            end
            // A write in an apply cycle is kept for the next apply point.
            if (cfg_we) begin
                pend.run    <= cfg_data[CFG_RUN_BIT];
                pend.sel    <= cfg_data[CFG_SEL_LSB +: CFG_SEL_W];
                cfg_pending <= 1'b1;
            end
            unique case (state)
                ST_HIGH: begin
                    if (terminal) begin
                        state     <= ST_LOW;
                        cpu_clk   <= 1'b0;
                        phase_cnt <= '0;
                    end
                end
                ST_LOW: begin
                    if (terminal) begin
                        phase_cnt <= '0;
                        if (go) begin
                            state    <= ST_HIGH;
                            cpu_clk  <= 1'b1;
                            cpu_rise <= 1'b1;
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                end
                ST_HELD: begin
                    if (base_tick && go) begin
                        state     <= ST_HIGH;
                        cpu_clk   <= 1'b1;
                        cpu_rise  <= 1'b1;
                        phase_cnt <= '0;
                    end
                end
                default: state <= ST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_rate_controller.sv
// Testbench for clock_rate_controller.
// Directed and random stimulus against a base-tick reference model.
module tb_clock_rate_controller;

    localparam int PRE  = 5;
    localparam int TDIV = 16;
    localparam int NS   = 2;

    logic          clock_in = 1'b0;
    logic          reset    = 1'b0;
    logic          cfg_we   = 1'b0;
    logic [7:0]    cfg_data = 8'h00;
    logic [NS-1:0] stall_req = '0;
    logic          cpu_clk;
    logic          cpu_rise;
    logic          tim_tick;
    logic [2:0]    rate_sel;
    logic          cfg_pending;

    clock_rate_controller #(
        .PRE_DIV  (PRE),
        .TICK_DIV (TDIV),
        .N_STALL  (NS)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_data    (cfg_data),
        .stall_req   (stall_req),
        .cpu_clk     (cpu_clk),
        .cpu_rise    (cpu_rise),
        .tim_tick    (tim_tick),
        .rate_sel    (rate_sel),
        .cfg_pending (cfg_pending)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    // Reference model: k counts clock_in edges since reset release;
    // every PRE-th edge is a base tick; phases measured in base ticks.
    int k;
    int m_state;  // 0 low, 1 high, 2 held
    int m_ticks;
    int m_sel;
    int m_run;
    int p_sel;
    int p_run;
    int m_pend;
    int m_clk;
    int m_rise;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; m_state = 0; m_ticks = 0;
        m_sel = 0; m_run = 1; p_sel = 0; p_run = 1;
        m_pend = 0; m_clk = 0; m_rise = 0;
    endtask

    task automatic model_edge(input bit we, input logic [7:0] d,
                              input bit st);
        int half;
        k++;
        m_rise = 0;
        if (k % PRE == 0) begin
            m_ticks++;
            half = 1 << m_sel;
            if (m_state == 1) begin
                if (m_ticks == half) begin
                    m_state = 0; m_clk = 0; m_ticks = 0;
                end
            end else if (m_state == 2 || m_ticks == half) begin
                if (m_pend != 0) begin
                    m_sel = p_sel; m_run = p_run; m_pend = 0;
                end
                m_ticks = 0;
                if (m_run != 0 && !st) begin
                    m_state = 1; m_clk = 1; m_rise = 1;
                end else begin
                    m_state = 2;
                end
            end
        end
        if (we) begin
            p_sel = int'(d[2:0]); p_run = int'(d[7]); m_pend = 1;
        end
    endtask

    task automatic compare_all();
        int exp_tim;
        exp_tim = (k > 0 && k % (PRE * TDIV) == 0) ? 1 : 0;
        chk("cpu_clk", cpu_clk, m_clk);
        chk("cpu_rise", cpu_rise, m_rise);
        chk("tim_tick", tim_tick, exp_tim);
        chk("rate_sel", rate_sel, m_sel);
        chk("cfg_pending", cfg_pending, m_pend);
    endtask

    task automatic step();
        @(posedge clock_in);
        if (!reset) model_edge(cfg_we, cfg_data, |stall_req);
        #1;
        compare_all();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (hold) step();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input logic [7:0] d);
        cfg_data = d;
        cfg_we = 1'b1;
        step();
    endtask

    task automatic wait_rise(output int n);
        bit found;
        found = 0;
        n = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            n++;
            found = cpu_rise;
        end
        chk("rise_timeout", found, 1);
    endtask

    task automatic high_len(input int exp, input string tag);
        int n;
        int w;
        wait_rise(w);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cpu_clk !== 1'b1) break;
            n++;
            step();
        end
        chk(tag, n, exp);
    endtask

    task automatic pulse_gap(input int which, input int exp,
                             input string tag);
        int n;
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            step();
            seen = (which != 0) ? tim_tick : cpu_rise;
        end
        n = 0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            step();
            n++;
            seen = (which != 0) ? tim_tick : cpu_rise;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int n;
        int rises;
        bit hit;
        logic [7:0] d;

        #2;
        do_reset(3);

        // Free run at SEL 0
        high_len(5, "high_sel0");
        pulse_gap(0, 10, "period_sel0");
        pulse_gap(1, 80, "tim_gap");

        // Rate change written mid HIGH
        wait_rise(n);
        step();
        step();
        write_cfg(8'h83);
        chk("pend_after_write", cfg_pending, 1);
        high_len(40, "high_sel3");
        chk("sel3_applied", rate_sel, 3);
        chk("pend_cleared", cfg_pending, 0);

        // Stall across the LOW terminal
        repeat (30) step();
        stall_req = 2'b10;
        repeat (23) step();
        chk("stall_hold_low", cpu_clk, 0);
        stall_req = 2'b00;
        wait_rise(n);
        chk("stall_release", (n <= PRE) ? 1 : 0, 1);
        pulse_gap(1, 80, "tim_gap_stall");

        // Halt, then restart
        wait_rise(n);
        write_cfg(8'h00);
        rises = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (cpu_rise === 1'b1) rises++;
        end
        chk("halt_no_rise", rises, 0);
        chk("halt_clk_low", cpu_clk, 0);
        write_cfg(8'h80);
        wait_rise(n);
        chk("restart_delay", (n <= PRE) ? 1 : 0, 1);

        // Two writes before apply: last wins
        wait_rise(n);
        write_cfg(8'h82);
        write_cfg(8'h85);
        high_len(160, "high_sel5");
        chk("sel5_applied", rate_sel, 5);

        // Write coinciding with an apply point
        write_cfg(8'h84);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (((k + 1) % PRE == 0) && m_state == 0
                && (m_ticks + 1) == (1 << m_sel)) hit = 1;
            else step();
        end
        chk("apply_found", hit, 1);
        write_cfg(8'h81);
        chk("coinc_pend", cfg_pending, 1);
        chk("coinc_sel", rate_sel, 4);

        // Reset mid HIGH at SEL 5
        write_cfg(8'h85);
        hit = 0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step();
            hit = (rate_sel === 3'd5 && cpu_clk === 1'b1);
        end
        chk("sel5_high_found", hit, 1);
        repeat (20) step();
        do_reset(2);
        chk("rst_clk", cpu_clk, 0);
        chk("rst_sel", rate_sel, 0);
        high_len(5, "high_after_rst");
        pulse_gap(0, 10, "period_after_rst");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0)
                stall_req = NS'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                d = 8'($urandom_range(0, 255));
                d[2:0] = 3'($urandom_range(0, 2));
                d[7] = ($urandom_range(0, 7) != 0);
                cfg_data = d;
                cfg_we = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_rate_controller.md
Name: clock_rate_controller

Overview:
Sequences the system clock datapath: prescales clock_in to a base tick, then derives a programmable-rate CPU clock and an independent timer tick.
Provides glitch-free CPU rate switching, a CPU run/halt control and CPU clock stretching on requester stall.
Sits between the board oscillator and the CPU/peripheral clock nets; configured over an 8-bit register write port.

Parameters:
PRE_DIV, 5, clock_in cycles per base tick (50 MHz -> 10 MHz base)
TICK_DIV, 16, base ticks per tim_tick pulse
N_STALL, 2, number of stall requesters

Ports:
clock_in  in  1  sole clock; all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
cfg_we  in  1  one-cycle write strobe for cfg_data
cfg_data  in  8  [2:0] rate select SEL, [7] RUN, [6:3] ignored
stall_req  in  N_STALL  level requests to hold cpu_clk low
cpu_clk  out  1  registered CPU clock
cpu_rise  out  1  one-cycle pulse, high in the same cycle cpu_clk goes 0->1
tim_tick  out  1  one-cycle pulse every TICK_DIV base ticks
rate_sel  out  3  SEL currently applied
cfg_pending  out  1  written config not yet applied

Behaviour:
- Reset values: cpu_clk 0, cpu_rise 0, tim_tick 0, rate_sel 0, cfg_pending 0. Active RUN = 1. Pending register = SEL 0, RUN 1. All counters 0. State = LOW.
- Prescaler:
  - pre_cnt counts 0..PRE_DIV-1 and wraps.
  - base_tick is internal and high in the cycle pre_cnt == PRE_DIV-1.
- Timer:
  - tick_cnt advances on base_tick, range 0..TICK_DIV-1.
  - tim_tick is registered and high for exactly one clock_in cycle when tick_cnt wraps.
  - Never affected by stall, halt or rate changes.
- Phase counter:
  - 8-bit, cleared on every cpu_clk edge, incremented on base_tick.
  - Half-period terminal is reached when phase_cnt == (1<<rate_sel)-1 on a base_tick.
  - Half period = 2^SEL base ticks. SEL 0 -> 5 MHz, SEL 7 -> 39.06 kHz (PRE_DIV 5, 50 MHz).
- State machine:
  - HIGH: at terminal -> LOW; cpu_clk <= 0.
  - LOW: at terminal, first apply the pending config (below), then:
    - if active RUN == 0 -> HELD
    - else if any stall_req -> HELD
    - else -> HIGH; cpu_clk <= 1, cpu_rise <= 1.
  - HELD: cpu_clk stays 0. On the first base_tick with active RUN == 1 and no stall_req -> HIGH; cpu_clk <= 1, cpu_rise <= 1.
- stall_req is sampled only at the LOW terminal and in HELD; it never shortens or truncates a HIGH phase.
- Config write:
  - cfg_we loads the pending register and sets cfg_pending.
  - Pending is applied (rate_sel, active RUN updated; cfg_pending cleared) only at a LOW terminal or on any base_tick in HELD. The first HIGH phase at the new rate is therefore full length.
  - A second write before apply overwrites the first; only the last value is applied.
  - cfg_we in the same cycle as an apply point: the old pending value is applied, the new value is stored, and cfg_pending stays 1.
- Mid-operation reset: every output drops to its reset value asynchronously. cpu_clk resumes at SEL 0 after release.
- Outputs cpu_clk, cpu_rise and tim_tick are flops, with no combinational path from any input.

Decomposition:
- Shared package/include `clk_ctrl_defs`:
  - state encoding: LOW, HIGH, HELD
  - cfg bit positions: CFG_SEL_LSB = 0, CFG_SEL_W = 3, CFG_RUN_BIT = 7
  - reset defaults
- One natural sub-module: `tick_divider` (parameterised modulo counter with wrap pulse). Instantiated for the prescaler and the timer.

Test Plan:
- Reset, then run free (SEL 0): cpu_clk period 10 clock_in cycles, 50% duty; cpu_rise 1 cycle wide per period; tim_tick every 80 cycles; rate_sel 0.
- Write 0x83 (SEL 3, RUN) mid HIGH phase:
  - cfg_pending stays 1 until the next LOW terminal;
  - the current HIGH/LOW phases remain 5 cycles each;
  - the next HIGH is 40 cycles;
  - rate_sel 3 and cfg_pending 0 after apply.
- stall_req[1] high across a LOW terminal for 23 cycles:
  - cpu_clk held 0;
  - rises on the first base_tick after release;
  - tim_tick spacing unchanged at 80.
- Write 0x00 (halt):
  - cpu_clk stops low after completing the current period;
  - no cpu_rise;
  - then writing 0x80 restarts on the next base_tick.
- Two writes, 0x82 then 0x85, before an apply point: only SEL 5 is applied (HIGH = 160 cycles); write coinciding with apply leaves cfg_pending 1.
- Assert reset mid HIGH at SEL 5: cpu_clk, cpu_rise, tim_tick, rate_sel go 0 in the same cycle; after release the 10-cycle period resumes.
